// File: rtl/uart_mem_scheduler_pkg.sv
// uart_mem_scheduler_pkg: register offsets, scheduler state encoding and
// event-source IDs shared by the UART/data-memory write scheduler.
package uart_mem_scheduler_pkg;

    // UART register block offsets relative to each UART base address
    localparam logic [31:0] OFF_TX_DATA = 32'd0;
    localparam logic [31:0] OFF_RX_FLAG = 32'd4;
    localparam logic [31:0] OFF_RX_DATA = 32'd8;
    localparam logic [31:0] OFF_TX_DONE = 32'd12;

    // Scheduler states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RX_DATA = 2'd1;
    localparam logic [1:0] ST_RX_FLAG = 2'd2;
    localparam logic [1:0] ST_TX_FLAG = 2'd3;

    // Event sources; also the bit positions in the request vector and the
    // round-robin order. Bit 0 of a source ID selects the UART channel.
    localparam logic [1:0] SRC_RX0 = 2'd0;
    localparam logic [1:0] SRC_RX1 = 2'd1;
    localparam logic [1:0] SRC_TX0 = 2'd2;
    localparam logic [1:0] SRC_TX1 = 2'd3;

endpackage

// File: rtl/uart_mem_scheduler_rr_pick4.sv
// rr_pick4: combinational 4-request round-robin picker. Searches from the
// pointer position upward (wrapping) and returns the first asserted request
// as a one-hot grant plus its index.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] cand;

    // Walk candidates from farthest to nearest so the nearest request wins
    always_comb begin
        gnt  = '0;
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                gnt = 4'b0001 << cand;
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_mem_scheduler.sv
// uart_mem_scheduler: shares the data-memory write port between the CPU and
// four UART event sources (rx0, rx1, tx0 done, tx1 done). Events are latched
// as pending requests and written back round-robin whenever the CPU leaves
// the bus free. Also gates CPU-initiated transmit starts.
// Optional: define UART_SCHED_OVERRUN_CNT_EN to add an 8-bit saturating
// overrun counter per rx channel, reported in bits [15:8] of the rx flag word.
module uart_mem_scheduler
    import uart_mem_scheduler_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] UART0_BASE = ADDR_W'(32'h0000_0F00),
    parameter logic [ADDR_W-1:0] UART1_BASE = ADDR_W'(32'h0000_0F10)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memReadCPU,
    input  logic              memWriteCPU,
    input  logic [ADDR_W-1:0] cpuAddress,
    input  logic              rxValid0,
    input  logic              rxValid1,
    input  logic [7:0]        rxData0,
    input  logic [7:0]        rxData1,
    input  logic              txBusy0,
    input  logic              txBusy1,
    output logic              txStart0,
    output logic              txStart1,
    output logic              memWriteOut,
    output logic [ADDR_W-1:0] memAddrOut,
    output logic [DATA_W-1:0] memDataOut,
    output logic              overrun0,
    output logic              overrun1
);

    localparam logic [ADDR_W-1:0] A_TX_DATA = ADDR_W'(OFF_TX_DATA);
    localparam logic [ADDR_W-1:0] A_RX_FLAG = ADDR_W'(OFF_RX_FLAG);
    localparam logic [ADDR_W-1:0] A_RX_DATA = ADDR_W'(OFF_RX_DATA);
    localparam logic [ADDR_W-1:0] A_TX_DONE = ADDR_W'(OFF_TX_DONE);

    logic              bus_free;
    logic [1:0]        state, cur_src, rr_ptr;
    logic              cur_ch;
    logic [1:0]        rx_vld, rx_pend, sh_vld, ovr_q, ovr_evt, rx_clr;
    logic [1:0]        tx_busy, tx_busy_q, tx_fall, tx_pend, tx_clr;
    logic [1:0][7:0]   rx_data, rx_buf, sh_buf;
    logic [3:0]        req, gnt;
    logic [1:0]        win;
    logic              win_any, wr_done, do_pick;
    logic [ADDR_W-1:0] cur_base;
    logic [DATA_W-1:0] flag_data;

    assign bus_free = !(memReadCPU | memWriteCPU);
    assign rx_vld   = {rxValid1, rxValid0};
    assign rx_data  = {rxData1, rxData0};
    assign tx_busy  = {txBusy1, txBusy0};
    assign tx_fall  = tx_busy_q & ~tx_busy;
    assign cur_ch   = cur_src[0];
    assign cur_base = cur_ch ? UART1_BASE : UART0_BASE;

    // A flag write retires the current source; it may hand straight over to
    // the next winner, but the retiring source is excluded from that pick.
    assign wr_done = bus_free & ((state == ST_RX_FLAG) | (state == ST_TX_FLAG));
    assign req     = {tx_pend, rx_pend} & ~(wr_done ? (4'b0001 << cur_src) : 4'b0000);
    assign do_pick = bus_free & win_any & ((state == ST_IDLE) | wr_done);
    assign rx_clr  = (wr_done && state == ST_RX_FLAG) ? (2'b01 << cur_ch) : 2'b00;
    assign tx_clr  = (wr_done && state == ST_TX_FLAG) ? (2'b01 << cur_ch) : 2'b00;
    assign ovr_evt = rx_vld & rx_pend & sh_vld;

    rr_pick4 u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (win),
        .any (win_any)
    );

    // Sequencer: pick a winner, then step through its data/flag writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cur_src <= SRC_RX0;
            rr_ptr  <= SRC_RX0;
        end else if (do_pick) begin
            cur_src <= win;
            rr_ptr  <= win + 2'd1;
            state   <= (|gnt[1:0]) ? ST_RX_DATA : ST_TX_FLAG;
        end else if (bus_free && state == ST_RX_DATA) begin
            state <= ST_RX_FLAG;
        end else if (wr_done) begin
            state <= ST_IDLE;
        end
    end

    // Rx pending/shadow/overrun control; a new byte always beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_pend <= '0;
            sh_vld  <= '0;
            ovr_q   <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (rx_vld[n]) begin
                    if (!rx_pend[n])     rx_pend[n] <= 1'b1;
                    else if (rx_clr[n])  sh_vld[n]  <= 1'b0;
                    else                 sh_vld[n]  <= 1'b1;
                    if (ovr_evt[n])      ovr_q[n]   <= 1'b1;
                end else if (rx_clr[n]) begin
                    if (sh_vld[n]) sh_vld[n]  <= 1'b0;
                    else           rx_pend[n] <= 1'b0;
                end
            end
        end
    end

    // Rx byte buffers: rxBuf frozen while pending, newer bytes go to shadow
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (rx_vld[n] && (!rx_pend[n] || rx_clr[n])) rx_buf[n] <= rx_data[n];
            else if (rx_clr[n] && sh_vld[n])             rx_buf[n] <= sh_buf[n];
            if (rx_vld[n] && rx_pend[n] && !rx_clr[n])   sh_buf[n] <= rx_data[n];
        end
    end

    // Tx-done capture on transmitter busy falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q <= '0;
            tx_pend   <= '0;
        end else begin
            tx_busy_q <= tx_busy;
            tx_pend   <= (tx_pend & ~tx_clr) | tx_fall;
        end
    end

`ifdef UART_SCHED_OVERRUN_CNT_EN
    logic [1:0][7:0] ovr_cnt;

    // Saturating overrun counters, cleared when reported in the flag word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (ovr_evt[n])
                    ovr_cnt[n] <= rx_clr[n] ? 8'd1 :
                                  (ovr_cnt[n] == 8'hFF) ? 8'hFF : ovr_cnt[n] + 8'd1;
                else if (rx_clr[n])
                    ovr_cnt[n] <= 8'd0;
            end
        end
    end

    assign flag_data = DATA_W'({16'h0000, ovr_cnt[cur_ch], 8'h01});
`else
    assign flag_data = DATA_W'(32'h1);
`endif

    // Memory write port: only driven while the CPU leaves the bus free
    always_comb begin
        memWriteOut = 1'b0;
        memAddrOut  = '0;
        memDataOut  = '0;
        if (bus_free) begin
            case (state)
                ST_RX_DATA: begin
                    memWriteOut = 1'b1;
                    memAddrOut  = cur_base + A_RX_DATA;
                    memDataOut  = DATA_W'(rx_buf[cur_ch]);
                end
                ST_RX_FLAG: begin
                    memWriteOut = 1'b1;
                    memAddrOut  = cur_base + A_RX_FLAG;
                    memDataOut  = flag_data;
                end
                ST_TX_FLAG: begin
                    memWriteOut = 1'b1;
                    memAddrOut  = cur_base + A_TX_DONE;
                    memDataOut  = DATA_W'(32'h1);
                end
                default: ;
            endcase
        end
    end

    assign txStart0 = rst_n & memWriteCPU & (cpuAddress == UART0_BASE + A_TX_DATA)
                      & ~txBusy0 & ~tx_pend[0];
    assign txStart1 = rst_n & memWriteCPU & (cpuAddress == UART1_BASE + A_TX_DATA)
                      & ~txBusy1 & ~tx_pend[1];
    assign overrun0 = ovr_q[0];
    assign overrun1 = ovr_q[1];

endmodule

// File: tb/tb_uart_mem_scheduler.sv
// tb_uart_mem_scheduler: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model of the scheduler.
`timescale 1ns/1ps
module tb_uart_mem_scheduler;

    localparam logic [31:0] B0 = 32'h0000_0F00;
    localparam logic [31:0] B1 = 32'h0000_0F10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memReadCPU, memWriteCPU;
    logic [31:0] cpuAddress;
    logic        rxValid0, rxValid1;
    logic [7:0]  rxData0, rxData1;
    logic        txBusy0, txBusy1;
    logic        txStart0, txStart1;
    logic        memWriteOut;
    logic [31:0] memAddrOut, memDataOut;
    logic        overrun0, overrun1;

    always #5 clk = ~clk;

    uart_mem_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .memReadCPU  (memReadCPU),
        .memWriteCPU (memWriteCPU),
        .cpuAddress  (cpuAddress),
        .rxValid0    (rxValid0),
        .rxValid1    (rxValid1),
        .rxData0     (rxData0),
        .rxData1     (rxData1),
        .txBusy0     (txBusy0),
        .txBusy1     (txBusy1),
        .txStart0    (txStart0),
        .txStart1    (txStart1),
        .memWriteOut (memWriteOut),
        .memAddrOut  (memAddrOut),
        .memDataOut  (memDataOut),
        .overrun0    (overrun0),
        .overrun1    (overrun1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    // kind: 0 = rx data word, 1 = rx flag word, 2 = tx done flag
    typedef struct { logic [31:0] addr; int kind; logic [7:0] b; } job_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } log_t;

    job_t       job[$];            // writes still owed by the source being serviced
    log_t       wlog[$];           // writes observed on the DUT port
    int         m_rxn[2];          // bytes waiting per rx channel (0..2)
    logic [7:0] m_rxv[2][2];       // [0] = byte being reported, [1] = next one
    bit         m_txp[2];
    bit         m_ovr[2];
    int         m_cnt[2];
    bit         m_pb[2];
    int         m_rr, m_cur;

    function automatic logic [31:0] base_of(input int ch);
        return (ch != 0) ? B1 : B0;
    endfunction

    function automatic logic [31:0] flag_word(input int ch);
`ifdef UART_SCHED_OVERRUN_CNT_EN
        return {16'h0000, 8'(m_cnt[ch]), 8'h01};
`else
        return (ch >= 0) ? 32'h1 : 32'h1;
`endif
    endfunction

    function automatic bit pending(input int s);
        return (s < 2) ? (m_rxn[s] > 0) : m_txp[s-2];
    endfunction

    task automatic m_reset();
        job.delete();
        for (int c = 0; c < 2; c++) begin
            m_rxn[c] = 0; m_txp[c] = 0; m_ovr[c] = 0; m_cnt[c] = 0; m_pb[c] = 0;
        end
        m_rr = 0; m_cur = 0;
    endtask

    task automatic m_step();
        bit   bf, done, found;
        int   dsrc, s;
        bit   oe[2];
        logic rv;
        logic [7:0] rd;
        bf = !(memReadCPU || memWriteCPU);
        done = 0; dsrc = -1;
        if (bf && job.size() > 0) begin
            void'(job.pop_front());
            if (job.size() == 0) begin done = 1; dsrc = m_cur; end
        end
        if (bf && job.size() == 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                s = (m_rr + k) % 4;
                if (!found && s != dsrc && pending(s)) begin
                    found = 1;
                    m_cur = s;
                    m_rr  = (s + 1) % 4;
                    if (s < 2) begin
                        job.push_back('{base_of(s) + 32'd8, 0, m_rxv[s][0]});
                        job.push_back('{base_of(s) + 32'd4, 1, 8'h00});
                    end else begin
                        job.push_back('{base_of(s-2) + 32'd12, 2, 8'h00});
                    end
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            rv = (c != 0) ? rxValid1 : rxValid0;
            rd = (c != 0) ? rxData1  : rxData0;
            oe[c] = 0;
            if (rv) begin
                if (m_rxn[c] < 2) begin
                    m_rxv[c][m_rxn[c]] = rd;
                    m_rxn[c]++;
                end else begin
                    m_rxv[c][1] = rd;
                    m_ovr[c] = 1;
                    oe[c] = 1;
                    if (m_cnt[c] < 255) m_cnt[c]++;
                end
            end
        end
        if (done) begin
            if (dsrc < 2) begin
                m_rxv[dsrc][0] = m_rxv[dsrc][1];
                m_rxn[dsrc]--;
                m_cnt[dsrc] = oe[dsrc] ? 1 : 0;
            end else begin
                m_txp[dsrc-2] = 0;
            end
        end
        for (int c = 0; c < 2; c++) begin
            rv = (c != 0) ? txBusy1 : txBusy0;
            if (m_pb[c] && !rv) m_txp[c] = 1;
            m_pb[c] = rv;
        end
    endtask

    task automatic check_outputs();
        bit          bf, ew;
        logic [31:0] ed;
        bf = !(memReadCPU || memWriteCPU);
        ew = bf && (job.size() > 0);
        chk("memWriteOut", memWriteOut, ew);
        if (ew) begin
            ed = (job[0].kind == 0) ? {24'h0, job[0].b} :
                 (job[0].kind == 1) ? flag_word(m_cur & 1) : 32'h1;
            chk("memAddrOut", memAddrOut, job[0].addr);
            chk("memDataOut", memDataOut, ed);
        end
        chk("txStart0", txStart0, memWriteCPU && cpuAddress == B0 && !txBusy0 && !m_txp[0]);
        chk("txStart1", txStart1, memWriteCPU && cpuAddress == B1 && !txBusy1 && !m_txp[1]);
        chk("overrun0", overrun0, m_ovr[0]);
        chk("overrun1", overrun1, m_ovr[1]);
        if (memWriteOut) wlog.push_back('{memAddrOut, memDataOut});
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst_n) m_step();
        #1;
    endtask

    task automatic quiet();
        memReadCPU = 0; memWriteCPU = 0; cpuAddress = 32'h0;
        rxValid0 = 0; rxValid1 = 0;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        m_reset();
        #1;
        chk({tag, "_wr"},   memWriteOut, 32'h0);
        chk({tag, "_addr"}, memAddrOut,  32'h0);
        chk({tag, "_data"}, memDataOut,  32'h0);
        chk({tag, "_ovr"},  {overrun1, overrun0}, 32'h0);
        chk({tag, "_txs"},  {txStart1, txStart0}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic chk_log(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
        if (i < wlog.size()) begin
            chk({tag, "_addr"}, wlog[i].addr, a);
            chk({tag, "_data"}, wlog[i].data, d);
        end
    endtask

    logic [31:0] flag1;

    initial begin
        quiet();
        rxData0 = 8'h00; rxData1 = 8'h00; txBusy0 = 0; txBusy1 = 0;
        do_reset("reset0");

        // Single rx0 byte on an idle bus
        wlog.delete();
        rxValid0 = 1; rxData0 = 8'hA5; tick(); quiet();
        repeat (4) tick();
        chk("t1_count", wlog.size(), 2);
        chk_log("t1_w0", 0, 32'h0F08, 32'h0000_00A5);
        chk_log("t1_w1", 1, 32'h0F04, 32'h1);

        // rx1 byte while the CPU holds the bus for 5 cycles
        wlog.delete();
        memWriteCPU = 1; cpuAddress = 32'h100; rxValid1 = 1; rxData1 = 8'h3C; tick();
        rxValid1 = 0;
        repeat (4) tick();
        chk("t2_held", wlog.size(), 0);
        quiet();
        repeat (4) tick();
        chk("t2_count", wlog.size(), 2);
        chk_log("t2_w0", 0, 32'h0F18, 32'h0000_003C);
        chk_log("t2_w1", 1, 32'h0F14, 32'h1);

        // All four sources in one cycle
        do_reset("reset1");
        txBusy0 = 1; txBusy1 = 1; tick();
        rxValid0 = 1; rxData0 = 8'h5A; rxValid1 = 1; rxData1 = 8'hC3;
        txBusy0 = 0; txBusy1 = 0; tick(); quiet();
        wlog.delete();
        repeat (7) tick();
        chk("t3_count", wlog.size(), 6);
        chk_log("t3_w0", 0, 32'h0F08, 32'h0000_005A);
        chk_log("t3_w1", 1, 32'h0F04, 32'h1);
        chk_log("t3_w2", 2, 32'h0F18, 32'h0000_00C3);
        chk_log("t3_w3", 3, 32'h0F14, 32'h1);
        chk_log("t3_w4", 4, 32'h0F0C, 32'h1);
        chk_log("t3_w5", 5, 32'h0F1C, 32'h1);

        // Three rx0 bytes while the CPU holds the bus -> overrun
        wlog.delete();
        memWriteCPU = 1; cpuAddress = 32'h100;
        rxValid0 = 1; rxData0 = 8'h11; tick();
        rxData0 = 8'h22; tick();
        rxData0 = 8'h33; tick();
        rxValid0 = 0; tick();
        chk("t4_overrun", overrun0, 1'b1);
        quiet();
        repeat (8) tick();
`ifdef UART_SCHED_OVERRUN_CNT_EN
        flag1 = 32'h0000_0101;
`else
        flag1 = 32'h0000_0001;
`endif
        chk("t4_count", wlog.size(), 4);
        chk_log("t4_w0", 0, 32'h0F08, 32'h0000_0011);
        chk_log("t4_w1", 1, 32'h0F04, flag1);
        chk_log("t4_w2", 2, 32'h0F08, 32'h0000_0033);
        chk_log("t4_w3", 3, 32'h0F04, 32'h1);

        // Transmit start gating
        memWriteCPU = 1; cpuAddress = B0; txBusy0 = 0; #1;
        chk("t5_start", txStart0, 1'b1);
        tick();
        txBusy0 = 1; #1;
        chk("t5_busy", txStart0, 1'b0);
        tick(); quiet();

        // Reset in the middle of an rx flag write
        rxValid0 = 1; rxData0 = 8'h77; tick(); quiet();
        tick(); tick();
        chk("t6_in_flag", memAddrOut, 32'h0F04);
        do_reset("t6_reset");
        wlog.delete();
        repeat (5) tick();
        chk("t6_no_write", wlog.size(), 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            memReadCPU  = ($urandom_range(0, 99) < 20);
            memWriteCPU = !memReadCPU && ($urandom_range(0, 99) < 20);
            case ($urandom_range(0, 3))
                0:       cpuAddress = B0;
                1:       cpuAddress = B1;
                2:       cpuAddress = B0 + 32'd4;
                default: cpuAddress = $urandom;
            endcase
            rxValid0 = ($urandom_range(0, 99) < 12); rxData0 = 8'($urandom);
            rxValid1 = ($urandom_range(0, 99) < 12); rxData1 = 8'($urandom);
            if ($urandom_range(0, 99) < 15) txBusy0 = ~txBusy0;
            if ($urandom_range(0, 99) < 15) txBusy1 = ~txBusy1;
            tick();
        end
        quiet();
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
